// File: rtl/audio_sd_dac.sv
// First-order sigma-delta audio DAC with a small sample FIFO.
// Samples from the voice mixer are buffered, released one per sample
// period into the current-sample register, and turned into a 1-bit
// pulse-density stream by a carry-out accumulator.
module audio_sd_dac #(
    parameter int DATA_W     = 12,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV        = 256
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [DATA_W-1:0]           s_data,
    output logic                        pdm_out,
    output logic                        underrun,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [AW:0]   LVL_FULL = (AW+1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV-1);

    // Handshake: a sample transfers on a rising edge where s_valid && s_ready.
    // s_ready depends on occupancy only, so upstream may hold s_valid and
    // s_data stable until the transfer without any combinational loop.

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       level_q, level_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] cur_q, cur_d;
    logic [DATA_W:0]   acc_q, acc_d;
    logic              pdm_q, pdm_d;

    logic              tick;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] u;

    assign s_ready    = (level_q != LVL_FULL);
    assign fifo_level = level_q;
    assign pdm_out    = pdm_q;

    // The sample tick fires on the last count of an enabled period.
    assign tick     = enable && (cnt_q == CNT_LAST);
    assign push     = s_valid && s_ready;
    // Pop decision uses the occupancy before this edge, so a sample pushed
    // on the tick cycle into an empty buffer is not visible to that tick.
    assign pop      = tick && (level_q != '0);
    assign underrun = tick && (level_q == '0);

    // Offset binary: flipping the sign bit adds 2^(DATA_W-1).
    assign u = {~cur_q[DATA_W-1], cur_q[DATA_W-2:0]};

    // Next-state logic for buffer bookkeeping, sample timer and modulator.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        cnt_d    = cnt_q;
        cur_d    = cur_q;
        acc_d    = acc_q;
        pdm_d    = 1'b0;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            cur_d    = mem_q[rd_ptr_q];
        end
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        // While disabled the counter keeps its position so the period
        // resumes where it stopped; the accumulator keeps its phase.
        if (enable) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
            acc_d = {1'b0, acc_q[DATA_W-1:0]} + {1'b0, u};
            pdm_d = acc_q[DATA_W];
        end
    end

    // Sample storage; contents need no reset because occupancy gates reads.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= s_data;
        end
    end

    // Control and datapath state with asynchronous reset to midscale idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            cnt_q    <= '0;
            cur_q    <= '0;
            acc_q    <= '0;
            pdm_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            cnt_q    <= cnt_d;
            cur_q    <= cur_d;
            acc_q    <= acc_d;
            pdm_q    <= pdm_d;
        end
    end

endmodule

// File: tb/tb_audio_sd_dac.sv
// Bench for audio_sd_dac: a queue-based behavioural model runs in lockstep
// and every output is compared each cycle, with scenario tasks adding
// targeted checks of density, timing, ordering and reset behaviour.
module tb_audio_sd_dac;
    localparam int DW    = 12;
    localparam int DEPTH = 4;
    localparam int DIV   = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_data = '0;
    logic          pdm_out;
    logic          underrun;
    logic [2:0]    fifo_level;

    int tests_run    = 0;
    int tests_failed = 0;
    bit chk_en       = 0;
    bit sb_en        = 0;

    logic [DW-1:0] exp_q[$];

    always #5 clk = ~clk;

    audio_sd_dac #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .DIV(DIV)) dut (
        .clk(clk), .rst(rst), .enable(enable), .s_valid(s_valid),
        .s_ready(s_ready), .s_data(s_data), .pdm_out(pdm_out),
        .underrun(underrun), .fifo_level(fifo_level)
    );

    // ---------------- behavioural model ----------------
    logic [DW-1:0] m_q[$];
    logic [DW-1:0] m_cur   = '0;
    int            m_cnt   = 0;
    int            m_frac  = 0;
    bit            m_carry = 0;
    bit            m_pdm   = 0;
    bit            m_popped = 0;
    int            m_sz;
    int            m_sum;
    bit            m_tick;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q.delete();
            m_cur = '0; m_cnt = 0; m_frac = 0; m_carry = 0; m_pdm = 0; m_popped = 0;
        end else begin
            m_sz     = m_q.size();
            m_tick   = enable && (m_cnt == DIV-1);
            m_popped = 0;
            if (enable) begin
                m_pdm   = m_carry;
                m_sum   = m_frac + (int'($signed(m_cur)) + 2048);
                m_carry = (m_sum >= 4096);
                m_frac  = m_sum % 4096;
                m_cnt   = (m_cnt + 1) % DIV;
            end else begin
                m_pdm = 0;
            end
            if (m_tick && m_sz > 0) begin
                m_cur    = m_q.pop_front();
                m_popped = 1;
            end
            if (s_valid && m_sz < DEPTH) m_q.push_back(s_data);
        end
    end

    // ---------------- lockstep output checker ----------------
    always @(negedge clk) begin
        #2;
        if (chk_en) begin
            tests_run++;
            if (pdm_out !== m_pdm) begin
                tests_failed++;
                $display("FAIL lockstep_pdm t=%0t: got %b expected %b", $time, pdm_out, m_pdm);
            end
            tests_run++;
            if (fifo_level !== 3'(m_q.size())) begin
                tests_failed++;
                $display("FAIL lockstep_level t=%0t: got %0d expected %0d", $time, fifo_level, m_q.size());
            end
            tests_run++;
            if (s_ready !== (m_q.size() < DEPTH)) begin
                tests_failed++;
                $display("FAIL lockstep_ready t=%0t: got %b expected %b", $time, s_ready, m_q.size() < DEPTH);
            end
            tests_run++;
            if (underrun !== (enable && m_cnt == DIV-1 && m_q.size() == 0)) begin
                tests_failed++;
                $display("FAIL lockstep_underrun t=%0t: got %b expected %b", $time, underrun,
                         enable && m_cnt == DIV-1 && m_q.size() == 0);
            end
        end
    end

    // ---------------- pop-order scoreboard ----------------
    logic [DW-1:0] sb_exp;
    always @(negedge clk) begin
        #1;
        if (sb_en && m_popped) begin
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL pop_order: got %h expected nothing queued", dut.cur_q);
            end else begin
                sb_exp = exp_q.pop_front();
                if (dut.cur_q !== sb_exp) begin
                    tests_failed++;
                    $display("FAIL pop_order: got %h expected %h", dut.cur_q, sb_exp);
                end
            end
        end
    end

    // ---------------- scenario tasks ----------------
    task automatic test_reset();
        chk_en = 1;
        rst = 1; enable = 0; s_valid = 0; s_data = '0;
        repeat (2) @(negedge clk);
        #1;
        tests_run++;
        if (fifo_level !== 3'd0) begin tests_failed++; $display("FAIL reset_level: got %0d expected 0", fifo_level); end
        tests_run++;
        if (s_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready: got %b expected 1", s_ready); end
        tests_run++;
        if (pdm_out !== 1'b0) begin tests_failed++; $display("FAIL reset_pdm: got %b expected 0", pdm_out); end
        tests_run++;
        if (underrun !== 1'b0) begin tests_failed++; $display("FAIL reset_underrun: got %b expected 0", underrun); end
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_idle_density();
        int ones = 0;
        int urs  = 0;
        int last = -1;
        @(negedge clk);
        enable = 1;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 4096; i++) begin
            @(negedge clk);
            #1;
            ones += int'(pdm_out);
            if (underrun === 1'b1) begin
                urs++;
                if (last >= 0) begin
                    tests_run++;
                    if (i - last != DIV) begin
                        tests_failed++;
                        $display("FAIL idle_underrun_spacing: got %0d expected %0d", i - last, DIV);
                    end
                end
                last = i;
            end
        end
        tests_run++;
        if (ones != 2048) begin tests_failed++; $display("FAIL idle_density: got %0d expected 2048", ones); end
        tests_run++;
        if (urs != 4096 / DIV) begin tests_failed++; $display("FAIL idle_underrun_count: got %0d expected %0d", urs, 4096 / DIV); end
    endtask

    task automatic test_fill();
        bit got = 0;
        @(negedge clk);
        enable = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            s_valid = 1;
            s_data  = DW'($urandom_range(0, 4095));
            #1;
            tests_run++;
            if (s_ready !== 1'b1) begin tests_failed++; $display("FAIL fill_ready_%0d: got %b expected 1", i, s_ready); end
        end
        @(negedge clk);
        s_data = DW'($urandom_range(0, 4095));
        #1;
        tests_run++;
        if (s_ready !== 1'b0) begin tests_failed++; $display("FAIL fill_full_ready: got %b expected 0", s_ready); end
        tests_run++;
        if (fifo_level !== 3'd4) begin tests_failed++; $display("FAIL fill_full_level: got %0d expected 4", fifo_level); end
        repeat (3) @(negedge clk);
        enable = 1;
        for (int i = 0; i < 2*DIV + 4; i++) begin
            @(negedge clk);
            #1;
            if (s_ready === 1'b1) begin got = 1; break; end
        end
        tests_run++;
        if (!got) begin tests_failed++; $display("FAIL fill_slot_timeout: got no slot expected one within %0d cycles", 2*DIV + 4); end
        @(negedge clk);
        s_valid = 0;
        #1;
        tests_run++;
        if (fifo_level !== 3'd4) begin tests_failed++; $display("FAIL fill_fifth_accepted: got %0d expected 4", fifo_level); end
        repeat (5*DIV) @(negedge clk);
        #1;
        tests_run++;
        if (fifo_level !== 3'd0) begin tests_failed++; $display("FAIL fill_drain: got %0d expected 0", fifo_level); end
    endtask

    task automatic run_density(input logic [DW-1:0] smp, input int want, input string name);
        int ones = 0;
        bit got = 0;
        @(negedge clk);
        s_valid = 1;
        s_data  = smp;
        @(negedge clk);
        s_valid = 0;
        for (int i = 0; i < 2*DIV + 4; i++) begin
            @(negedge clk);
            #1;
            if (fifo_level === 3'd0) begin got = 1; break; end
        end
        tests_run++;
        if (!got) begin tests_failed++; $display("FAIL %s_pop_timeout: got level %0d expected 0", name, fifo_level); end
        repeat (4) @(negedge clk);
        for (int i = 0; i < 4096; i++) begin
            @(negedge clk);
            #1;
            ones += int'(pdm_out);
        end
        tests_run++;
        if (ones != want) begin tests_failed++; $display("FAIL %s: got %0d expected %0d", name, ones, want); end
    endtask

    task automatic test_extremes();
        enable = 1;
        run_density(12'h7FF, 4095, "density_max");
        run_density(12'h800, 0, "density_min");
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] d;
        bit found;
        exp_q.delete();
        sb_en = 1;
        @(negedge clk);
        enable = 1;
        found = 0;
        for (int j = 0; j < 2*DIV + 2; j++) begin
            @(negedge clk);
            if (m_cnt == 0) begin found = 1; break; end
        end
        for (int i = 0; i < 2; i++) begin
            s_valid = 1;
            d = DW'($urandom_range(0, 4095));
            s_data = d;
            exp_q.push_back(d);
            @(negedge clk);
        end
        s_valid = 0;
        for (int k = 0; k < 8; k++) begin
            found = 0;
            for (int j = 0; j < 2*DIV + 2; j++) begin
                @(negedge clk);
                if (m_cnt == DIV-1) begin found = 1; break; end
            end
            tests_run++;
            if (!found) begin
                tests_failed++;
                $display("FAIL b2b_tick_timeout: got no tick expected one within %0d cycles", 2*DIV + 2);
            end else begin
                s_valid = 1;
                d = DW'($urandom_range(0, 4095));
                s_data = d;
                exp_q.push_back(d);
                #1;
                tests_run++;
                if (underrun !== 1'b0) begin tests_failed++; $display("FAIL b2b_underrun: got %b expected 0", underrun); end
                @(negedge clk);
                s_valid = 0;
                #1;
                tests_run++;
                if (fifo_level !== 3'd2) begin tests_failed++; $display("FAIL b2b_level_%0d: got %0d expected 2", k, fifo_level); end
            end
        end
        repeat (3*DIV + 4) @(negedge clk);
        #1;
        tests_run++;
        if (fifo_level !== 3'd0) begin tests_failed++; $display("FAIL b2b_drain: got %0d expected 0", fifo_level); end
        sb_en = 0;
    endtask

    task automatic test_reset_mid();
        int exp_pdm[4];
        exp_pdm = '{0, 0, 1, 0};
        @(negedge clk);
        enable = 0;
        for (int i = 0; i < 3; i++) begin
            s_valid = 1;
            s_data  = DW'($urandom_range(0, 4095));
            @(negedge clk);
        end
        s_valid = 0;
        enable  = 1;
        repeat (5) @(negedge clk);
        rst = 1;
        #1;
        tests_run++;
        if (fifo_level !== 3'd0) begin tests_failed++; $display("FAIL rstmid_level: got %0d expected 0", fifo_level); end
        tests_run++;
        if (s_ready !== 1'b1) begin tests_failed++; $display("FAIL rstmid_ready: got %b expected 1", s_ready); end
        tests_run++;
        if (pdm_out !== 1'b0) begin tests_failed++; $display("FAIL rstmid_pdm: got %b expected 0", pdm_out); end
        @(negedge clk);
        rst = 0;
        for (int e = 0; e < 4; e++) begin
            @(negedge clk);
            #1;
            tests_run++;
            if (pdm_out !== 1'(exp_pdm[e])) begin
                tests_failed++;
                $display("FAIL rstmid_restart_%0d: got %b expected %0d", e, pdm_out, exp_pdm[e]);
            end
        end
    endtask

    task automatic test_enable_gap();
        bit found = 0;
        enable = 1;
        for (int i = 0; i < 2*DIV + 2; i++) begin
            @(negedge clk);
            #1;
            if (underrun === 1'b1) begin found = 1; break; end
        end
        tests_run++;
        if (!found) begin tests_failed++; $display("FAIL gap_tick_timeout: got no underrun expected one within %0d cycles", 2*DIV + 2); end
        repeat (6) @(negedge clk);
        enable = 0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            #1;
            tests_run++;
            if (pdm_out !== 1'b0) begin tests_failed++; $display("FAIL gap_pdm_%0d: got %b expected 0", i, pdm_out); end
            tests_run++;
            if (underrun !== 1'b0) begin tests_failed++; $display("FAIL gap_underrun_%0d: got %b expected 0", i, underrun); end
        end
        enable = 1;
        #1;
        for (int e = 0; e <= 10; e++) begin
            if (e > 0) begin
                @(negedge clk);
                #1;
            end
            tests_run++;
            if (underrun !== (e == 10)) begin
                tests_failed++;
                $display("FAIL gap_resume_%0d: got %b expected %b", e, underrun, e == 10);
            end
        end
    endtask

    task automatic test_random();
        exp_q.delete();
        sb_en = 1;
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            enable  = ($urandom_range(0, 9) != 0);
            s_valid = ($urandom_range(0, 11) == 0);
            s_data  = DW'($urandom_range(0, 4095));
            #1;
            if (s_valid && s_ready) exp_q.push_back(s_data);
        end
        @(negedge clk);
        s_valid = 0;
        enable  = 1;
        repeat (6*DIV) @(negedge clk);
        #1;
        tests_run++;
        if (fifo_level !== 3'd0) begin tests_failed++; $display("FAIL random_drain: got %0d expected 0", fifo_level); end
        sb_en = 0;
    endtask

    initial begin
        test_reset();
        test_idle_density();
        test_fill();
        test_extremes();
        test_back_to_back();
        test_reset_mid();
        test_enable_gap();
        test_random();
        @(negedge clk);
        #3;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
